rbus_source_stage: RTL and testbench

Register-file and R-bus source stage of the micro-alpha datapath. Holds general registers R0–R7 and the address register RA, and drives the R bus from the source named by the microinstruction's 4-bit `RBUS_SOURCE_SELECTOR` field. Write-back arrives from the result path. The R-bus output is registered, one cycle after the selector, for consumption by the ALU stage.

---
 rtl/rbus_source_stage.sv | 138 +++++++++++++
 tb/tb_rbus_source_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rbus_source_stage.sv
// rbus_source_stage: R0-R7/RA register file and registered R-bus source mux.
// Define RBUS_WRITE_BYPASS_EN to forward same-cycle write data onto rbus.
module rbus_source_stage #(
    parameter int DATA_WIDTH = 16,
    parameter int SLT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [3:0]            rbus_sel,
    input  logic [SLT_WIDTH-1:0]  slt,
    input  logic [DATA_WIDTH-1:0] llt,
    input  logic                  wr_en,
    input  logic [3:0]            wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rbus,
    output logic                  rbus_valid,
    output logic [DATA_WIDTH-1:0] ra,
    output logic                  illegal_sel
);

    localparam logic [3:0] SEL_RA  = 4'b1000;
    localparam logic [3:0] SEL_RAP = 4'b1001;
    localparam logic [3:0] SEL_SLT = 4'b1010;
    localparam logic [3:0] SEL_LLT = 4'b1011;
    localparam logic [3:0] SEL_NRB = 4'b1111;

    logic [DATA_WIDTH-1:0] gpr_q [8];
    logic [DATA_WIDTH-1:0] ra_q;
    logic [DATA_WIDTH-1:0] rbus_q;
    logic                  valid_q;
    logic                  ill_q;

    logic                  wr_gpr;
    logic                  wr_ra;
    logic [DATA_WIDTH-1:0] gpr_rd;
    logic [DATA_WIDTH-1:0] ra_rd;
    logic [DATA_WIDTH-1:0] rbus_d;
    logic                  valid_d;
    logic                  ill_d;
    logic [DATA_WIDTH-1:0] ra_d;

    logic sel_gpr;
    logic sel_ra;
    logic sel_rap;
    logic sel_slt;
    logic sel_llt;
    logic sel_nrb;
    logic sel_bad;

    always_comb begin
        sel_gpr = ~rbus_sel[3];
        sel_ra  = (rbus_sel == SEL_RA);
        sel_rap = (rbus_sel == SEL_RAP);
        sel_slt = (rbus_sel == SEL_SLT);
        sel_llt = (rbus_sel == SEL_LLT);
        sel_nrb = (rbus_sel == SEL_NRB);
        sel_bad = rbus_sel[3] & rbus_sel[2]
                & ~(rbus_sel[1] & rbus_sel[0]);
    end

    // Only R0-R7 and RA accept write-back; other codes are dropped.
    always_comb begin
        wr_gpr = wr_en & ~wr_sel[3];
        wr_ra  = wr_en & (wr_sel == SEL_RA);
    end

    always_comb begin
        gpr_rd = gpr_q[rbus_sel[2:0]];
        ra_rd  = ra_q;
`ifdef RBUS_WRITE_BYPASS_EN
        if (wr_gpr && (wr_sel[2:0] == rbus_sel[2:0])) begin
            gpr_rd = wr_data;
        end
        if (wr_ra) begin
            ra_rd = wr_data;
        end
`endif
    end

    always_comb begin
        rbus_d  = '0;
        valid_d = 1'b1;
        ill_d   = 1'b0;
        unique case (1'b1)
            sel_gpr: rbus_d = gpr_rd;
            sel_ra:  rbus_d = ra_rd;
            sel_rap: rbus_d = ra_rd;
            sel_slt: rbus_d = DATA_WIDTH'(slt);
            sel_llt: rbus_d = llt;
            sel_nrb: valid_d = 1'b0;
            sel_bad: begin
                valid_d = 1'b0;
                ill_d   = 1'b1;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // A write to RA overrides any post-increment in the same cycle.
    always_comb begin
        ra_d = ra_q;
        if (!stall && sel_rap) begin
            ra_d = ra_q + DATA_WIDTH'(1);
        end
        if (wr_ra) begin
            ra_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                gpr_q[i] <= '0;
            end
            ra_q    <= '0;
            rbus_q  <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            if (wr_gpr) begin
                gpr_q[wr_sel[2:0]] <= wr_data;
            end
            ra_q <= ra_d;
            if (!stall) begin
                rbus_q  <= rbus_d;
                valid_q <= valid_d;
                ill_q   <= ill_d;
            end
        end
    end

    assign rbus        = rbus_q;
    assign rbus_valid  = valid_q;
    assign ra          = ra_q;
    assign illegal_sel = ill_q;

endmodule

// File: tb/tb_rbus_source_stage.sv
// tb_rbus_source_stage: scoreboard bench for the R-bus source stage.
// Directed scenarios plus a randomised phase against a reference model.
module tb_rbus_source_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [3:0]  rbus_sel;
    logic [7:0]  slt;
    logic [15:0] llt;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [15:0] wr_data;
    logic [15:0] rbus;
    logic        rbus_valid;
    logic [15:0] ra;
    logic        illegal_sel;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] rbus;
        logic        valid;
        logic        ill;
        logic [15:0] ra;
    } exp_t;

    exp_t sb_q[$];

    logic [15:0] m_r [8];
    logic [15:0] m_ra;
    logic [15:0] m_rbus;
    logic        m_valid;
    logic        m_ill;

    always #5 clk = ~clk;

    rbus_source_stage #(
        .DATA_WIDTH(16),
        .SLT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .rbus_sel   (rbus_sel),
        .slt        (slt),
        .llt        (llt),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .rbus       (rbus),
        .rbus_valid (rbus_valid),
        .ra         (ra),
        .illegal_sel(illegal_sel)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] sel, input logic st,
                         input logic we, input logic [3:0] ws,
                         input logic [15:0] wd, input logic rst);
        logic [15:0] rv;
        logic [15:0] nra;
        logic        wrr;
        logic        wrg;
        exp_t        e;
        wrr = we && (ws == 4'd8);
        wrg = we && (ws < 4'd8);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_r[i] = '0;
            m_ra    = '0;
            m_rbus  = '0;
            m_valid = 1'b0;
            m_ill   = 1'b0;
        end else begin
            rv = '0;
            if (sel < 4'd8) begin
                rv = m_r[sel[2:0]];
`ifdef RBUS_WRITE_BYPASS_EN
                if (wrg && ws == sel) rv = wd;
`endif
            end else if (sel == 4'd8 || sel == 4'd9) begin
                rv = m_ra;
`ifdef RBUS_WRITE_BYPASS_EN
                if (wrr) rv = wd;
`endif
            end
            if (!st) begin
                if (sel <= 4'd9) begin
                    m_rbus = rv; m_valid = 1; m_ill = 0;
                end else if (sel == 4'd10) begin
                    m_rbus = {8'h00, slt}; m_valid = 1; m_ill = 0;
                end else if (sel == 4'd11) begin
                    m_rbus = llt; m_valid = 1; m_ill = 0;
                end else if (sel == 4'd15) begin
                    m_rbus = '0; m_valid = 0; m_ill = 0;
                end else begin
                    m_rbus = '0; m_valid = 0; m_ill = 1;
                end
            end
            nra = m_ra;
            if (!st && sel == 4'd9) nra = m_ra + 16'd1;
            if (wrr) nra = wd;
            m_ra = nra;
            if (wrg) m_r[ws[2:0]] = wd;
        end
        e.rbus  = m_rbus;
        e.valid = m_valid;
        e.ill   = m_ill;
        e.ra    = m_ra;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] sel, input logic st,
                        input logic we, input logic [3:0] ws,
                        input logic [15:0] wd, input logic rst);
        exp_t e;
        @(negedge clk);
        rbus_sel = sel;
        stall    = st;
        wr_en    = we;
        wr_sel   = ws;
        wr_data  = wd;
        reset    = rst;
        model(sel, st, we, ws, wd, rst);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_rbus",  {16'h0, rbus},  {16'h0, e.rbus});
            check("sb_valid", {31'h0, rbus_valid}, {31'h0, e.valid});
            check("sb_ill",   {31'h0, illegal_sel}, {31'h0, e.ill});
            check("sb_ra",    {16'h0, ra},    {16'h0, e.ra});
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; rbus_sel = 4'hF;
        slt = '0; llt = '0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;

        step(4'hF, 0, 0, 4'h0, 16'h0, 1);
        check("reset_rbus",  {16'h0, rbus}, 32'h0);
        check("reset_valid", {31'h0, rbus_valid}, 32'h0);
        check("reset_ra",    {16'h0, ra}, 32'h0);

        step(4'hF, 0, 1, 4'h3, 16'h1234, 0);
        step(4'h3, 0, 0, 4'h0, 16'h0, 0);
        check("r3_rbus",  {16'h0, rbus}, 32'h1234);
        check("r3_valid", {31'h0, rbus_valid}, 32'h1);

        step(4'hF, 0, 1, 4'h8, 16'hFFFE, 0);
        check("ra_write", {16'h0, ra}, 32'hFFFE);
        step(4'h9, 0, 0, 4'h0, 16'h0, 0);
        check("rap0", {16'h0, rbus}, 32'hFFFE);
        step(4'h9, 0, 0, 4'h0, 16'h0, 0);
        check("rap1", {16'h0, rbus}, 32'hFFFF);
        step(4'h9, 0, 0, 4'h0, 16'h0, 0);
        check("rap2", {16'h0, rbus}, 32'h0000);
        check("rap_ra", {16'h0, ra}, 32'h0001);

        slt = 8'hA5;
        step(4'hA, 0, 0, 4'h0, 16'h0, 0);
        check("slt", {16'h0, rbus}, 32'h00A5);
        llt = 16'hBEEF;
        step(4'hB, 0, 0, 4'h0, 16'h0, 0);
        check("llt", {16'h0, rbus}, 32'hBEEF);
        step(4'hF, 0, 0, 4'h0, 16'h0, 0);
        check("nrb_rbus",  {16'h0, rbus}, 32'h0);
        check("nrb_valid", {31'h0, rbus_valid}, 32'h0);

        step(4'hD, 0, 0, 4'h0, 16'h0, 0);
        check("bad_ill",   {31'h0, illegal_sel}, 32'h1);
        check("bad_valid", {31'h0, rbus_valid}, 32'h0);
        step(4'h0, 0, 0, 4'h0, 16'h0, 0);
        check("r0_ill", {31'h0, illegal_sel}, 32'h0);
        check("r0_rbus", {16'h0, rbus}, 32'h0);

        step(4'hF, 0, 1, 4'h5, 16'h1111, 0);
        step(4'h5, 0, 1, 4'h5, 16'h5555, 0);
`ifdef RBUS_WRITE_BYPASS_EN
        check("r5_coll", {16'h0, rbus}, 32'h5555);
`else
        check("r5_coll", {16'h0, rbus}, 32'h1111);
`endif
        step(4'h5, 0, 0, 4'h0, 16'h0, 0);
        check("r5_after", {16'h0, rbus}, 32'h5555);

        llt = 16'hCAFE;
        step(4'hB, 0, 1, 4'h8, 16'h0010, 0);
        step(4'h9, 1, 0, 4'h0, 16'h0, 0);
        check("stall_rbus", {16'h0, rbus}, 32'hCAFE);
        check("stall_ra",   {16'h0, ra}, 32'h0010);
        step(4'h9, 1, 1, 4'h1, 16'h0007, 0);
        check("stall_rbus2", {16'h0, rbus}, 32'hCAFE);
        check("stall_ra2",   {16'h0, ra}, 32'h0010);
        step(4'h1, 0, 0, 4'h0, 16'h0, 0);
        check("r1_after", {16'h0, rbus}, 32'h0007);
        step(4'h9, 0, 0, 4'h0, 16'h0, 0);
        check("rap_post", {16'h0, rbus}, 32'h0010);
        check("rap_post_ra", {16'h0, ra}, 32'h0011);
        step(4'h9, 0, 0, 4'h0, 16'h0, 1);
        check("mid_rst_rbus", {16'h0, rbus}, 32'h0);
        check("mid_rst_ra",   {16'h0, ra}, 32'h0);
        check("mid_rst_vld",  {31'h0, rbus_valid}, 32'h0);
        step(4'h8, 0, 0, 4'h0, 16'h0, 0);
        check("ra_after_rst", {16'h0, rbus}, 32'h0);
        check("ra_after_vld", {31'h0, rbus_valid}, 32'h1);
        step(4'h1, 0, 0, 4'h0, 16'h0, 0);
        check("r1_cleared", {16'h0, rbus}, 32'h0);

        step(4'hF, 0, 1, 4'h8, 16'h0100, 0);
        step(4'h9, 0, 1, 4'h8, 16'h0200, 0);
`ifdef RBUS_WRITE_BYPASS_EN
        check("rap_wr_rbus", {16'h0, rbus}, 32'h0200);
`else
        check("rap_wr_rbus", {16'h0, rbus}, 32'h0100);
`endif
        check("rap_wr_ra", {16'h0, ra}, 32'h0200);
        step(4'h8, 0, 1, 4'h9, 16'hFFFF, 0);
        check("wr_rap_ign", {16'h0, rbus}, 32'h0200);
        step(4'h8, 0, 1, 4'hC, 16'hFFFF, 0);
        check("wr_bad_ign", {16'h0, ra}, 32'h0200);
        step(4'hC, 0, 0, 4'h0, 16'h0, 0);
        check("bad_c", {31'h0, illegal_sel}, 32'h1);
        step(4'hE, 1, 0, 4'h0, 16'h0, 0);
        check("bad_stall", {31'h0, illegal_sel}, 32'h1);
        step(4'hF, 0, 0, 4'h0, 16'h0, 0);
        check("nrb_clr", {31'h0, illegal_sel}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            slt = 8'($urandom);
            llt = 16'($urandom);
            step(4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1),
                 4'($urandom_range(0, 15)),
                 16'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
